// File: rtl/lane_fill_engine_pkg.sv
// lane_fill_engine_pkg: lane geometry, colour constants and fill FSM states shared by playfield logic
package lane_fill_engine_pkg;
  localparam int NUM_LANES    = 5;
  localparam int LANE_START_X = 120;
  localparam int LANE_PITCH   = 80;
  localparam int FILL_OFFSET  = 10;
  localparam int FILL_WIDTH   = 60;
  localparam int Y_START      = 0;
  localparam int Y_END        = 479;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;
  localparam int COLOR_W      = 9;
  localparam logic [8:0] BLACK = 9'h000;
  localparam logic [8:0] WHITE = 9'h1ff;
  localparam logic [8:0] RED   = 9'h1c0;
  localparam logic [8:0] GREEN = 9'h038;
  localparam logic [8:0] BLUE  = 9'h007;
  typedef enum logic [1:0] {IDLE, FILL, WAIT_LOW} fill_state_e;
endpackage

// File: rtl/lane_fill_engine_lane_pick.sv
// lane_pick: lowest set mask bit at index >= from, with a none-left flag
module lane_pick #(
  parameter int N  = 5,
  parameter int LW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [LW-1:0] from,
  output logic [LW-1:0] lane,
  output logic          none
);
  always_comb begin
    lane = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && LW'(i) >= from) begin
        lane = LW'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/lane_fill_engine.sv
// lane_fill_engine: fills the playable strip of masked lanes with one colour
// through a stallable valid/ready pixel-write port.
module lane_fill_engine #(
  parameter int NUM_LANES    = lane_fill_engine_pkg::NUM_LANES,
  parameter int LANE_START_X = lane_fill_engine_pkg::LANE_START_X,
  parameter int LANE_PITCH   = lane_fill_engine_pkg::LANE_PITCH,
  parameter int FILL_OFFSET  = lane_fill_engine_pkg::FILL_OFFSET,
  parameter int FILL_WIDTH   = lane_fill_engine_pkg::FILL_WIDTH,
  parameter int Y_START      = lane_fill_engine_pkg::Y_START,
  parameter int Y_END        = lane_fill_engine_pkg::Y_END,
  parameter int X_W          = lane_fill_engine_pkg::X_W,
  parameter int Y_W          = lane_fill_engine_pkg::Y_W,
  parameter int COLOR_W      = lane_fill_engine_pkg::COLOR_W
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic [COLOR_W-1:0]   fill_color,
  input  logic                 abort,
  input  logic                 pix_ready,
  output logic                 pix_write,
  output logic [X_W-1:0]       pix_x,
  output logic [Y_W-1:0]       pix_y,
  output logic [COLOR_W-1:0]   pix_color,
  output logic                 busy,
  output logic                 done
);
  import lane_fill_engine_pkg::fill_state_e;
  import lane_fill_engine_pkg::IDLE;
  import lane_fill_engine_pkg::FILL;
  import lane_fill_engine_pkg::WAIT_LOW;
  localparam int LW   = $clog2(NUM_LANES + 1);
  localparam int XO_W = $clog2(FILL_WIDTH + 1);
  if (LANE_START_X + (NUM_LANES - 1) * LANE_PITCH + FILL_OFFSET + FILL_WIDTH - 1 >= 2 ** X_W) begin : g_x_chk
    $error("lane_fill_engine: maximum pixel x does not fit in X_W bits");
  end
  if (Y_END >= 2 ** Y_W) begin : g_y_chk
    $error("lane_fill_engine: Y_END does not fit in Y_W bits");
  end
  fill_state_e            state_q, state_d;
  logic                   start_d_q, start_d_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [XO_W-1:0]        xoff_q, xoff_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [X_W-1:0]         x_q, x_d;
  logic                   write_q, write_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_LANES-1:0]   pick_mask;
  logic [LW-1:0]          pick_from, pick_lane;
  logic                   pick_none, beat, last_x, last_y;
  assign beat      = write_q & pix_ready;
  assign last_x    = xoff_q == XO_W'(FILL_WIDTH - 1);
  assign last_y    = y_q == Y_W'(Y_END);
  assign pick_mask = state_q == IDLE ? lane_mask : mask_q;
  assign pick_from = state_q == IDLE ? '0 : lane_q + LW'(1);
  lane_pick #(.N(NUM_LANES), .LW(LW)) u_pick (
    .mask(pick_mask),
    .from(pick_from),
    .lane(pick_lane),
    .none(pick_none)
  );
  always_comb begin
    start_d_d = start;
    state_d   = state_q;
    mask_d    = mask_q;
    color_d   = color_q;
    lane_d    = lane_q;
    xoff_d    = xoff_q;
    y_d       = y_q;
    x_d       = x_q;
    write_d   = write_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start && !start_d_q) begin
        mask_d  = lane_mask;
        color_d = fill_color;
        if (pick_none) begin
          done_d  = 1'b1;
          state_d = WAIT_LOW;
        end else begin
          lane_d  = pick_lane;
          xoff_d  = '0;
          y_d     = Y_W'(Y_START);
          write_d = 1'b1;
          busy_d  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: if (beat) begin
        xoff_d = last_x ? '0 : xoff_q + 1'b1;
        if (last_x) y_d = last_y ? Y_W'(Y_START) : y_q + 1'b1;
        if (last_x && last_y) begin
          lane_d  = pick_none ? lane_q : pick_lane;
          write_d = !pick_none;
          busy_d  = !pick_none;
          done_d  = pick_none;
          state_d = pick_none ? WAIT_LOW : FILL;
        end
      end
      WAIT_LOW: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort outranks a simultaneous beat, completion or start edge
    if (abort) begin
      write_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      state_d = start ? WAIT_LOW : IDLE;
    end
    if (state_d == FILL) x_d = X_W'(LANE_START_X + int'(lane_d) * LANE_PITCH + FILL_OFFSET + int'(xoff_d));
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      start_d_q <= 1'b1;
      mask_q    <= '0;
      color_q   <= '0;
      lane_q    <= '0;
      xoff_q    <= '0;
      y_q       <= Y_W'(Y_START);
      x_q       <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_d_q <= start_d_d;
      mask_q    <= mask_d;
      color_q   <= color_d;
      lane_q    <= lane_d;
      xoff_q    <= xoff_d;
      y_q       <= y_d;
      x_q       <= x_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign pix_write = write_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_color = color_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_lane_fill_engine.sv
// tb_lane_fill_engine: table-driven cycle vectors plus hand sequences for stalls, abort and reset
module tb_lane_fill_engine;
  localparam int FW = 2;
  localparam int YS = 2;
  localparam int YE = 3;
  logic       Clock = 1'b0;
  logic       Resetn, start, abort, pix_ready;
  logic [4:0] lane_mask;
  logic [8:0] fill_color;
  logic       pix_write, busy, done;
  logic [9:0] pix_x;
  logic [8:0] pix_y, pix_color;
  int total = 0;
  int bad = 0;
  lane_fill_engine #(
    .NUM_LANES(5), .LANE_START_X(120), .LANE_PITCH(80), .FILL_OFFSET(10),
    .FILL_WIDTH(FW), .Y_START(YS), .Y_END(YE), .X_W(10), .Y_W(9), .COLOR_W(9)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .lane_mask(lane_mask),
    .fill_color(fill_color), .abort(abort), .pix_ready(pix_ready),
    .pix_write(pix_write), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy), .done(done)
  );
  always #5 Clock = ~Clock;
  typedef struct {
    logic st; logic [4:0] m; logic [8:0] c; logic ab; logic rdy;
    logic w; logic b; logic d; int x; int y; int ec;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t v(logic st, logic [4:0] m, logic [8:0] c, logic ab, logic rdy,
                             logic w, logic b, logic d, int x, int y, int ec);
    vec_t r;
    r = '{st, m, c, ab, rdy, w, b, d, x, y, ec};
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input logic [4:0] m, input logic [8:0] c, input bit rnd, input int abort_at);
    int ex[$];
    int ey[$];
    int idx = 0;
    int cyc = 0;
    int lows = 0;
    int px, py;
    logic w;
    bit fin = 0;
    for (int l = 0; l < 5; l++)
      if (m[l])
        for (int y = YS; y <= YE; y++)
          for (int x = 0; x < FW; x++) begin
            ex.push_back(130 + 80 * l + x);
            ey.push_back(y);
          end
    @(negedge Clock);
    start = 1'b1; lane_mask = m; fill_color = c; pix_ready = 1'b1; abort = 1'b0;
    @(posedge Clock); #1;
    chk("first_write", int'(pix_write), 1);
    chk("first_busy", int'(busy), 1);
    while (!fin && cyc < 200) begin
      @(negedge Clock);
      lane_mask = 5'b0; fill_color = 9'h0;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = idx == abort_at;
      if (!pix_ready) lows++;
      w = pix_write; px = int'(pix_x); py = int'(pix_y);
      cyc++;
      @(posedge Clock); #1;
      if (abort) begin
        chk("abort_write", int'(pix_write), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        fin = 1;
      end else if (w && pix_ready) begin
        chk($sformatf("x[%0d]", idx), px, ex[idx]);
        chk($sformatf("y[%0d]", idx), py, ey[idx]);
        chk("color", int'(pix_color), int'(c));
        idx++;
        if (idx == ex.size()) begin
          chk("last_done", int'(done), 1);
          chk("last_write", int'(pix_write), 0);
          chk("last_busy", int'(busy), 0);
          fin = 1;
        end else chk("mid_done", int'(done), 0);
      end else begin
        chk("write_held", int'(w), 1);
        chk("stall_x", int'(pix_x), px);
        chk("stall_y", int'(pix_y), py);
        chk("stall_write", int'(pix_write), 1);
      end
    end
    chk("finished", int'(fin), 1);
    if (abort_at < 0) chk("cycles", cyc, ex.size() + lows);
    @(negedge Clock);
    abort = 1'b0; start = 1'b0; pix_ready = 1'b1;
    @(posedge Clock); #1;
    chk("done_clear", int'(done), 0);
    chk("idle_write", int'(pix_write), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end
  initial begin
    Resetn = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    lane_mask = 5'b0; fill_color = 9'h0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_write", int'(pix_write), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), YS);
    chk("rst_color", int'(pix_color), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    vt.push_back(v(0, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(1, 5'b00010, 9'h1a5, 0, 1, 1, 1, 0, 210, 2, 'h1a5));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 0, 1, 1, 0, 210, 2, 'h1a5));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 211, 2, 'h1a5));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 210, 3, 'h1a5));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 211, 3, 'h1a5));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 0, 0, 1,   0, 0, 0));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(1, 5'b00001, 9'h0f0, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(0, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(1, 5'b00000, 9'h0aa, 0, 1, 0, 0, 1,   0, 0, 0));
    vt.push_back(v(0, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(1, 5'b10100, 9'h007, 0, 1, 1, 1, 0, 290, 2, 'h007));
    vt.push_back(v(1, 5'b00000, 9'h000, 1, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(0, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    vt.push_back(v(1, 5'b10001, 9'h1ff, 0, 1, 1, 1, 0, 130, 2, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 131, 2, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 130, 3, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 131, 3, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 450, 2, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 451, 2, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 450, 3, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 1, 1, 0, 451, 3, 'h1ff));
    vt.push_back(v(1, 5'b00000, 9'h000, 0, 1, 0, 0, 1,   0, 0, 0));
    vt.push_back(v(0, 5'b00000, 9'h000, 0, 1, 0, 0, 0,   0, 0, 0));
    foreach (vt[i]) begin
      if (i != 0) @(negedge Clock);
      start = vt[i].st; lane_mask = vt[i].m; fill_color = vt[i].c;
      abort = vt[i].ab; pix_ready = vt[i].rdy;
      @(posedge Clock); #1;
      chk($sformatf("v%0d_write", i), int'(pix_write), int'(vt[i].w));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vt[i].b));
      chk($sformatf("v%0d_done", i), int'(done), int'(vt[i].d));
      if (vt[i].w) begin
        chk($sformatf("v%0d_x", i), int'(pix_x), vt[i].x);
        chk($sformatf("v%0d_y", i), int'(pix_y), vt[i].y);
        chk($sformatf("v%0d_color", i), int'(pix_color), vt[i].ec);
      end
    end
    @(negedge Clock);
    start = 1'b0; abort = 1'b0;
    run(5'b10100, 9'h123, 1'b1, -1);
    run(5'b01011, 9'h055, 1'b1, 5);
    run(5'b01011, 9'h0c3, 1'b0, -1);
    @(negedge Clock);
    Resetn = 1'b0; start = 1'b1; lane_mask = 5'b00001;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clock); #1;
      chk("held_write", int'(pix_write), 0);
      chk("held_busy", int'(busy), 0);
      chk("held_done", int'(done), 0);
    end
    @(negedge Clock);
    start = 1'b0;
    run(5'b00001, 9'h1c0, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clock); #1;
      chk("after_write", int'(pix_write), 0);
      chk("after_done", int'(done), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
